// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns completed SPI command words into config writes, reset pulses and operation launches.
// Optional build macro SPI_CMD_PARITY_EN adds an even-parity check on bit 0 of every word.
module spi_cmd_decoder #(
    parameter int BITS_SPI     = 32,
    parameter int NUM_BUFBYTES = 10,
    parameter int RST_PULSE    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n_spi,
    input  logic                      spi_busy,
    input  logic [BITS_SPI-1:0]       spi_word,
    output logic [BITS_SPI-1:0]       spi_resp,
    output logic [8*NUM_BUFBYTES-1:0] cfg_regs,
    output logic                      rst_dly,
    output logic                      rst_pixel,
    output logic                      rst_analog,
    output logic                      op_start,
    output logic [1:0]                op_sel,
    input  logic                      op_done,
    output logic [3:0]                state
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'h0,
        ST_RESET_DLY    = 4'h4,
        ST_RESET_PIXEL  = 4'h5,
        ST_RESET_ANALOG = 4'h6,
        ST_DLY_CALIB    = 4'h8,
        ST_PIXEL_CALIB  = 4'h9,
        ST_MAIN_WORK    = 4'hA,
        ST_ERR          = 4'hF
    } state_t;

    localparam logic [3:0] CMD_SET = 4'h2;
    localparam logic [3:0] CMD_GET = 4'h3;
    localparam int         PW      = $clog2(RST_PULSE + 1);

    state_t          cur, nxt, prev_st, cmd_st;
    logic            busy_s1, busy_s2, busy_h, word_valid, upd_q;
    logic [3:0]      cmd, addr, last_cmd;
    logic [7:0]      data, resp_data, err_cnt, seq_cnt;
    logic            addr_ok, cmd_ok, cmd_op, par_err, bad, exec, err_inc, is_rst, is_op;
    logic [PW-1:0]   pcnt;
    logic [7:0]      cfg_mem [NUM_BUFBYTES];
    logic            unused_bits;

    assign cmd         = spi_word[31:28];
    assign addr        = spi_word[27:24];
    assign data        = spi_word[23:16];
    assign unused_bits = ^spi_word[15:0];
    assign word_valid  = busy_h & ~busy_s2;
    assign addr_ok     = 32'(addr) < NUM_BUFBYTES;
    assign cmd_ok      = cmd inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
    assign cmd_op      = cmd inside {4'h8, 4'h9, 4'hA};
    assign cmd_st      = (cmd inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA}) ? state_t'(cmd) : ST_IDLE;
    assign is_rst      = cur inside {ST_RESET_DLY, ST_RESET_PIXEL, ST_RESET_ANALOG};
    assign is_op       = cur inside {ST_DLY_CALIB, ST_PIXEL_CALIB, ST_MAIN_WORK};

`ifdef SPI_CMD_PARITY_EN
    assign par_err = ^spi_word;
`else
    assign par_err = 1'b0;
`endif

    assign bad = par_err | ~cmd_ok | (((cmd == CMD_SET) | (cmd == CMD_GET)) & ~addr_ok);

    // two-flop synchroniser for the sclk-domain busy flag plus one history flop for edge detect
    always_ff @(posedge clk or negedge rst_n_spi)
        if (!rst_n_spi) {busy_s1, busy_s2, busy_h} <= '0;
        else {busy_s1, busy_s2, busy_h} <= {spi_busy, busy_s1, busy_s2};

    // state register with the pulse-width counter that times the reset states
    always_ff @(posedge clk or negedge rst_n_spi)
        if (!rst_n_spi) begin
            cur     <= ST_IDLE;
            prev_st <= ST_IDLE;
            pcnt    <= '0;
        end else begin
            cur     <= nxt;
            prev_st <= cur;
            pcnt    <= is_rst ? pcnt + 1'b1 : '0;
        end

    // next state: pulse timeout, op completion and error recovery first, then decode of an idle-time word
    always_comb begin
        nxt     = cur;
        exec    = 1'b0;
        err_inc = 1'b0;
        if (is_rst && 32'(pcnt) == RST_PULSE - 1) nxt = ST_IDLE;
        if (is_op && op_done) nxt = ST_IDLE;
        if (cur == ST_ERR) nxt = ST_IDLE;
        if (word_valid) begin
            err_inc = (cur != ST_IDLE) | bad;
            exec    = (cur == ST_IDLE) & ~bad;
            if (cur == ST_IDLE) nxt = bad ? ST_ERR : cmd_st;
        end
    end

    // per-word bookkeeping: counters, config writes, readback data and the op launch strobe
    always_ff @(posedge clk or negedge rst_n_spi)
        if (!rst_n_spi) begin
            cfg_mem   <= '{default: '0};
            last_cmd  <= '0;
            resp_data <= '0;
            err_cnt   <= '0;
            seq_cnt   <= '0;
            op_start  <= 1'b0;
        end else begin
            if (word_valid) begin
                seq_cnt   <= seq_cnt + 8'd1;
                last_cmd  <= cmd;
                resp_data <= (exec && cmd == CMD_GET) ? cfg_mem[addr] : 8'h00;
            end
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (exec && cmd == CMD_SET) cfg_mem[addr] <= data;
            op_start <= exec & cmd_op;
        end

    // response word refreshes one clock after a decode and whenever the state changes
    always_ff @(posedge clk or negedge rst_n_spi)
        if (!rst_n_spi) begin
            upd_q    <= 1'b0;
            spi_resp <= '0;
        end else begin
            upd_q <= word_valid;
            if (upd_q || cur != prev_st) spi_resp <= {cur, last_cmd, resp_data, err_cnt, seq_cnt};
        end

    for (genvar i = 0; i < NUM_BUFBYTES; i++) begin : g_cfg
        assign cfg_regs[8*i +: 8] = cfg_mem[i];
    end

    assign state      = cur;
    assign rst_dly    = cur == ST_RESET_DLY;
    assign rst_pixel  = cur == ST_RESET_PIXEL;
    assign rst_analog = cur == ST_RESET_ANALOG;
    assign op_sel     = cur == ST_DLY_CALIB   ? 2'b01 :
                        cur == ST_PIXEL_CALIB ? 2'b10 :
                        cur == ST_MAIN_WORK   ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: scoreboard bench for spi_cmd_decoder (honours SPI_CMD_PARITY_EN when defined).
module tb_spi_cmd_decoder;

    localparam int RST_PULSE = 4;

    logic        clk = 1'b0;
    logic        rst_n_spi, spi_busy, op_done;
    logic [31:0] spi_word, spi_resp;
    logic [79:0] cfg_regs;
    logic        rst_dly, rst_pixel, rst_analog, op_start;
    logic [1:0]  op_sel;
    logic [3:0]  state;

    logic [7:0]  m_cfg [16];
    logic [7:0]  m_err, m_seq;
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    spi_cmd_decoder #(.BITS_SPI(32), .NUM_BUFBYTES(10), .RST_PULSE(RST_PULSE)) dut (
        .clk(clk), .rst_n_spi(rst_n_spi), .spi_busy(spi_busy), .spi_word(spi_word),
        .spi_resp(spi_resp), .cfg_regs(cfg_regs), .rst_dly(rst_dly), .rst_pixel(rst_pixel),
        .rst_analog(rst_analog), .op_start(op_start), .op_sel(op_sel), .op_done(op_done),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion before 5ms");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] a, input logic [7:0] d);
        logic [31:0] w;
        w = {c, a, d, 16'h0000};
`ifdef SPI_CMD_PARITY_EN
        w[0] = ^w;
`endif
        return w;
    endfunction

    function automatic logic [79:0] cfg_flat();
        logic [79:0] f;
        for (int i = 0; i < 10; i++) f[8*i +: 8] = m_cfg[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cfg[i] = 8'h00;
        m_err = 8'h00;
        m_seq = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_word(input logic [31:0] w, input bit busy, input logic [3:0] busy_st);
        logic [3:0] c, a, st;
        logic [7:0] d, rd;
        bit legal, bad;
        c = w[31:28];
        a = w[27:24];
        d = w[23:16];
        rd = 8'h00;
        case (c)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        bad = !legal || ((c == 4'h2 || c == 4'h3) && a >= 4'd10);
`ifdef SPI_CMD_PARITY_EN
        if (^w) bad = 1'b1;
`endif
        m_seq = m_seq + 8'd1;
        if (busy || bad) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            st = busy ? busy_st : 4'hF;
        end else begin
            st = (c >= 4'h4) ? c : 4'h0;
            if (c == 4'h3) rd = m_cfg[a];
            if (c == 4'h2) m_cfg[a] = d;
        end
        exp_q.push_back({st, c, rd, m_err, m_seq});
    endtask

    task automatic send_word(input logic [31:0] w, input bit done_dec);
        @(negedge clk);
        spi_word = w;
        spi_busy = 1'b1;
        repeat (2) @(negedge clk);
        spi_busy = 1'b0;
        repeat (2) @(posedge clk);
        if (done_dec) begin
            @(negedge clk);
            op_done = 1'b1;
        end
        @(posedge clk);
        #1;
        op_done = 1'b0;
    endtask

    task automatic watch(input int n, input logic [31:0] old, input logic [3:0] st_code,
                         output logic [31:0] first, output bit got, output int c_pulse,
                         output int c_any, output int c_start, output int c_st);
        first = '0; got = 1'b0; c_pulse = 0; c_any = 0; c_start = 0; c_st = 0;
        repeat (n) begin
            @(negedge clk);
            if ((st_code == 4'h4 && rst_dly) || (st_code == 4'h5 && rst_pixel) ||
                (st_code == 4'h6 && rst_analog)) c_pulse++;
            if (rst_dly || rst_pixel || rst_analog) c_any++;
            if (op_start) c_start++;
            if (state === st_code) c_st++;
            if (!got && spi_resp !== old) begin
                got = 1'b1;
                first = spi_resp;
            end
        end
    endtask

    task automatic xfer(input logic [31:0] w, input bit busy, input logic [3:0] bst, input bit done_dec,
                        input logic [3:0] st_code, output logic [31:0] first, output bit got,
                        output int c_pulse, output int c_any, output int c_start, output int c_st);
        logic [31:0] old;
        old = spi_resp;
        model_word(w, busy, bst);
        send_word(w, done_dec);
        watch(8, old, st_code, first, got, c_pulse, c_any, c_start, c_st);
    endtask

    task automatic test_reset();
        rst_n_spi = 1'b0; spi_busy = 1'b0; spi_word = '0; op_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (spi_resp !== 32'h0) begin n_bad++; $display("FAIL reset_resp: got %h want 0", spi_resp); end
        n_cmp++; if (state !== 4'h0) begin n_bad++; $display("FAIL reset_state: got %h want 0", state); end
        n_cmp++; if (cfg_regs !== 80'h0) begin n_bad++; $display("FAIL reset_cfg: got %h want 0", cfg_regs); end
        n_cmp++; if ({rst_dly, rst_pixel, rst_analog, op_start, op_sel} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000000", {rst_dly, rst_pixel, rst_analog, op_start, op_sel});
        end
        rst_n_spi = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (spi_resp !== 32'h0 || state !== 4'h0) begin
            n_bad++; $display("FAIL post_reset: got resp %h state %h want 0/0", spi_resp, state);
        end
    endtask

    task automatic test_reg_set_get();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        logic [3:0] adr [3] = '{4'd3, 4'd0, 4'd9};
        logic [7:0] val [3] = '{8'hA5, 8'h11, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            xfer(mk(4'h2, adr[i], val[i]), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
            ex = exp_q.pop_front();
            n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_set%0d: got %h want %h", i, first, ex); end
            n_cmp++; if (cfg_regs !== cfg_flat()) begin n_bad++; $display("FAIL cfg_set%0d: got %h want %h", i, cfg_regs, cfg_flat()); end
        end
        for (int i = 0; i < 3; i++) begin
            xfer(mk(4'h3, adr[i], 8'h00), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
            ex = exp_q.pop_front();
            n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_get%0d: got %h want %h", i, first, ex); end
        end
        xfer(mk(4'h1, 4'h2, 8'h77), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_dummy: got %h want %h", first, ex); end
    endtask

    task automatic test_reg_range();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        xfer(mk(4'h2, 4'd12, 8'h5A), 1'b0, 4'h0, 1'b0, 4'hF, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_set_oor: got %h want %h", first, ex); end
        n_cmp++; if (cst != 1) begin n_bad++; $display("FAIL err_state_len: got %0d cycles want 1", cst); end
        n_cmp++; if (cfg_regs !== cfg_flat()) begin n_bad++; $display("FAIL cfg_oor: got %h want %h", cfg_regs, cfg_flat()); end
        n_cmp++; if (state !== 4'h0) begin n_bad++; $display("FAIL state_after_err: got %h want 0", state); end
        xfer(mk(4'h3, 4'd10, 8'h00), 1'b0, 4'h0, 1'b0, 4'hF, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_get_oor: got %h want %h", first, ex); end
    endtask

    task automatic test_reset_pulses();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        for (int c = 4; c <= 6; c++) begin
            xfer(mk(4'(c), 4'h0, 8'h00), 1'b0, 4'h0, 1'b0, 4'(c), first, got, cp, ca, cs, cst);
            ex = exp_q.pop_front();
            n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_rst%0d: got %h want %h", c, first, ex); end
            n_cmp++; if (cp != RST_PULSE || ca != RST_PULSE) begin
                n_bad++; $display("FAIL pulse_len%0d: got %0d/%0d cycles want %0d", c, cp, ca, RST_PULSE);
            end
            n_cmp++; if (cst != RST_PULSE || state !== 4'h0) begin
                n_bad++; $display("FAIL rst_state%0d: got %0d cycles end %h want %0d end 0", c, cst, state, RST_PULSE);
            end
        end
    endtask

    task automatic test_main_work_busy();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        xfer(mk(4'hA, 4'h0, 8'h00), 1'b0, 4'h0, 1'b0, 4'hA, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_work: got %h want %h", first, ex); end
        n_cmp++; if (cs != 1) begin n_bad++; $display("FAIL work_start: got %0d pulses want 1", cs); end
        n_cmp++; if (op_sel !== 2'b11 || state !== 4'hA) begin
            n_bad++; $display("FAIL work_sel: got sel %b state %h want 11/a", op_sel, state);
        end
        xfer(mk(4'h1, 4'h0, 8'h00), 1'b1, 4'hA, 1'b0, 4'hA, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_busy: got %h want %h", first, ex); end
        n_cmp++; if (cs != 0 || cst != 8) begin
            n_bad++; $display("FAIL busy_no_effect: got starts %0d work cycles %0d want 0/8", cs, cst);
        end
        @(negedge clk);
        op_done = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (state !== 4'h0) begin n_bad++; $display("FAIL work_done: got %h want 0", state); end
        @(negedge clk);
        op_done = 1'b0;
        n_cmp++; if (op_sel !== 2'b00) begin n_bad++; $display("FAIL sel_idle: got %b want 00", op_sel); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_op_done_cases();
        logic [31:0] first, ex, old;
        bit got;
        int cp, ca, cs, cst;
        old = spi_resp;
        @(negedge clk);
        op_done = 1'b1;
        repeat (3) @(negedge clk);
        op_done = 1'b0;
        n_cmp++; if (state !== 4'h0 || spi_resp !== old) begin
            n_bad++; $display("FAIL done_idle: got state %h resp %h want 0/%h", state, spi_resp, old);
        end
        xfer(mk(4'h9, 4'h0, 8'h00), 1'b0, 4'h0, 1'b0, 4'h9, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_pcal: got %h want %h", first, ex); end
        n_cmp++; if (cs != 1 || op_sel !== 2'b10) begin
            n_bad++; $display("FAIL pcal_start: got %0d pulses sel %b want 1/10", cs, op_sel);
        end
        xfer(mk(4'h1, 4'h0, 8'h00), 1'b1, 4'h0, 1'b1, 4'h9, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_done_word: got %h want %h", first, ex); end
        n_cmp++; if (cst != 0 || state !== 4'h0) begin
            n_bad++; $display("FAIL done_word_state: got %0d cycles end %h want 0/0", cst, state);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        xfer(mk(4'h8, 4'h0, 8'h00), 1'b0, 4'h0, 1'b0, 4'h8, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex || cs != 1 || op_sel !== 2'b01) begin
            n_bad++; $display("FAIL dcal: got resp %h starts %0d sel %b want %h/1/01", first, cs, op_sel, ex);
        end
        @(negedge clk);
        rst_n_spi = 1'b0;
        #1;
        n_cmp++; if (state !== 4'h0 || op_sel !== 2'b00 || spi_resp !== 32'h0 || cfg_regs !== 80'h0) begin
            n_bad++; $display("FAIL midop_reset: got state %h sel %b resp %h cfg %h want all 0", state, op_sel, spi_resp, cfg_regs);
        end
        model_reset();
        @(negedge clk);
        rst_n_spi = 1'b1;
        watch(6, spi_resp, 4'h8, first, got, cp, ca, cs, cst);
        n_cmp++; if (cs != 0 || cst != 0) begin
            n_bad++; $display("FAIL no_restart: got starts %0d op cycles %0d want 0/0", cs, cst);
        end
        model_word(mk(4'h6, 4'h0, 8'h00), 1'b0, 4'h0);
        send_word(mk(4'h6, 4'h0, 8'h00), 1'b0);
        n_cmp++; if (rst_analog !== 1'b1) begin n_bad++; $display("FAIL analog_on: got %b want 1", rst_analog); end
        #2;
        rst_n_spi = 1'b0;
        #1;
        n_cmp++; if (rst_analog !== 1'b0) begin n_bad++; $display("FAIL analog_cut: got %b want 0", rst_analog); end
        model_reset();
        @(negedge clk);
        rst_n_spi = 1'b1;
        xfer(mk(4'h1, 4'h0, 8'h00), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_after_rst: got %h want %h", first, ex); end
    endtask

    task automatic test_parity();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
`ifdef SPI_CMD_PARITY_EN
        xfer(mk(4'h2, 4'h3, 8'h05) ^ 32'h1, 1'b0, 4'h0, 1'b0, 4'hF, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex || cst != 1) begin
            n_bad++; $display("FAIL parity_bad: got resp %h err cycles %0d want %h/1", first, cst, ex);
        end
        n_cmp++; if (cfg_regs !== cfg_flat()) begin n_bad++; $display("FAIL parity_nowrite: got %h want %h", cfg_regs, cfg_flat()); end
        xfer(mk(4'h2, 4'h3, 8'h05), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
`else
        xfer(mk(4'h2, 4'h3, 8'h06) | 32'h1, 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL bit0_ignored: got %h want %h", first, ex); end
        n_cmp++; if (cfg_regs !== cfg_flat()) begin n_bad++; $display("FAIL bit0_cfg: got %h want %h", cfg_regs, cfg_flat()); end
        xfer(mk(4'h2, 4'h3, 8'h05), 1'b0, 4'h0, 1'b0, 4'h0, first, got, cp, ca, cs, cst);
`endif
        ex = exp_q.pop_front();
        n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL parity_ok: got %h want %h", first, ex); end
        n_cmp++; if (cfg_regs[31:24] !== m_cfg[3]) begin n_bad++; $display("FAIL parity_cfg3: got %h want %h", cfg_regs[31:24], m_cfg[3]); end
    endtask

    task automatic test_illegal_saturate();
        logic [31:0] first, ex;
        bit got;
        int cp, ca, cs, cst;
        logic [3:0] bad_c [7] = '{4'h0, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        for (int i = 0; i < 260; i++) begin
            xfer(mk(bad_c[i % 7], i[3:0], i[7:0]), 1'b0, 4'h0, 1'b0, 4'hF, first, got, cp, ca, cs, cst);
            ex = exp_q.pop_front();
            n_cmp++; if (!got || first !== ex) begin n_bad++; $display("FAIL resp_illegal%0d: got %h want %h", i, first, ex); end
            if (m_seq == 8'h00) begin
                n_cmp++; if (first[7:0] !== 8'h00) begin n_bad++; $display("FAIL seq_wrap: got %h want 00", first[7:0]); end
            end
        end
        n_cmp++; if (spi_resp[15:8] !== 8'hFF || state !== 4'h0) begin
            n_bad++; $display("FAIL err_sat: got err %h state %h want ff/0", spi_resp[15:8], state);
        end
    endtask

    initial begin
        test_reset();
        test_reg_set_get();
        test_reg_range();
        test_reset_pulses();
        test_main_work_busy();
        test_op_done_cases();
        test_reset_mid_op();
        test_parity();
        test_illegal_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
